fb_write_ctrl: RTL
==================

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 Parameter AW, 8, frame-buffer address width (2^AW entries).
REQ-002 Parameter DW, 3, pixel width, RGB 111.
REQ-003 Parameter CLR_COLOR, 3'b000, value written by the clear engine.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port clear_req  in  1  synchronous pulse requesting a full-buffer clear.
REQ-007 Port bntr  in  1  asynchronous push-button, move cursor right.
REQ-008 Port bntl  in  1  asynchronous push-button, move cursor left.
REQ-009 Port color_sel  in  DW  paint colour, sampled when the paint write occurs.
REQ-010 Port vblank  in  1  write permission; buffer writes occur only while high.
REQ-011 Port wr_addr  out  AW  frame-buffer write address.
REQ-012 Port wr_data  out  DW  frame-buffer write data.
REQ-013 Port wr_en  out  1  frame-buffer write strobe, one entry per cycle while high.
REQ-014 Port cursor  out  AW  current cursor address.
REQ-015 Port busy  out  1  high whenever state is not IDLE.
REQ-016 Port done  out  1  one-cycle pulse on clear completion.

Function
REQ-017 FSM states: IDLE, CLEAR, PAINT; encoding is free.
REQ-018 bntr and bntl each pass a 2-flop synchroniser plus an edge register; a rising edge of the synchronised level sets pend_r or pend_l 3 clk edges after the input rises.
REQ-019 clear_req sets pend_c on the edge where it is sampled high.
REQ-020 Pending flags are one-deep; further events while a flag is already set are dropped.
REQ-021 IDLE priority: pend_c > (pend_r xor pend_l); pend_c set -> CLEAR, clear counter loaded with 0, pend_c cleared.
REQ-022 IDLE, pend_r only -> cursor+1 (wraps 2^AW-1 -> 0), pend_r cleared, go PAINT.
REQ-023 IDLE, pend_l only -> cursor-1 (wraps 0 -> 2^AW-1), pend_l cleared, go PAINT.
REQ-024 IDLE, pend_r and pend_l both set -> both cleared, cursor unchanged, stay IDLE, no write.
REQ-025 wr_en = (state is CLEAR or PAINT) and vblank, combinational; no other write source.
REQ-026 CLEAR: wr_addr = clear counter, wr_data = CLR_COLOR; counter increments only on cycles with wr_en high.
REQ-027 CLEAR: the write at address 2^AW-1 moves the FSM to IDLE and done is high during the following cycle only.
REQ-028 Clear with vblank held high takes exactly 2^AW write cycles; vblank low pauses it without loss or repetition of addresses.
REQ-029 PAINT: wr_addr = cursor, wr_data = color_sel; on the first cycle with vblank high one write occurs and the FSM returns to IDLE.
REQ-030 In IDLE wr_addr = cursor and wr_data = color_sel, with wr_en low.
REQ-031 Events arriving in CLEAR or PAINT are latched per REQ-020 and serviced from IDLE afterward; clear_req during CLEAR sets pend_c, causing a second clear.
REQ-032 Cursor is not altered by CLEAR.

Reset
REQ-033 rst high asynchronously forces: state IDLE, cursor 0, clear counter 0, pend_r/pend_l/pend_c 0, synchroniser and edge flops 0, done 0; hence wr_en 0, busy 0.
REQ-034 rst during CLEAR aborts the clear; no automatic restart after release.
REQ-035 First edge-sensitive action happens no earlier than the first rising clk edge after rst deasserts.

Verification
REQ-036 Reset, vblank=1, clear_req pulse -> busy next cycle, wr_en high 256 consecutive cycles with addr 0..255, data 000, done pulse exactly once afterwards.
REQ-037 Clear with vblank toggling 10 on / 5 off -> every address 0..255 written exactly once, in order, no writes while vblank=0.
REQ-038 cursor=255, bntl pulse then bntr pulse twice (sequenced, vblank=1, color_sel=100) -> cursor 254, 255, 0; writes (254,100), (255,100), (0,100).
REQ-039 bntr and bntl rising same cycle -> no cursor change, no wr_en.
REQ-040 bntr pulse during a clear at addr 100 -> clear completes uninterrupted, then cursor+1 and one paint write.
REQ-041 rst asserted mid-clear at addr 50 -> wr_en drops immediately, cursor 0, no further writes after release without a new clear_req.

Source files
------------

// File: rtl/fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// fb_write_ctrl
//
// Write-side controller for a small frame buffer. It provides two functions:
//   * a clear engine that sweeps every address 0 .. 2^AW-1 and writes
//     CLR_COLOR to each one, and
//   * a cursor that two push-buttons move left and right. Each move paints
//     the new cursor position with color_sel.
// The frame buffer may only be written while vblank is high. Any write that
// is waiting simply stalls until vblank returns, and no write is lost.
//
// Handshake: this block has no valid/ready pair. The frame buffer accepts one
// entry on every rising clk edge where wr_en is high. wr_addr and wr_data are
// meaningful only in those cycles.
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   clear_req  in   synchronous pulse that requests a full-buffer clear
//   bntr/bntl  in   asynchronous push-buttons that move the cursor right/left
//   color_sel  in   paint colour, used in the cycle the paint write happens
//   vblank     in   write permission
//   wr_addr    out  frame-buffer write address
//   wr_data    out  frame-buffer write data
//   wr_en      out  frame-buffer write strobe
//   cursor     out  current cursor address
//   busy       out  high whenever the FSM is not idle
//   done       out  one-cycle pulse in the cycle after the last clear write
//   dbg_state  out  raw FSM state, for observation only
// ---------------------------------------------------------------------------
module fb_write_ctrl #(
    parameter int              AW        = 8,
    parameter int              DW        = 3,
    parameter logic [DW-1:0]   CLR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    input  logic          bntr,
    input  logic          bntl,
    input  logic [DW-1:0] color_sel,
    input  logic          vblank,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_en,
    output logic [AW-1:0] cursor,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PAINT = 2'd2
    } state_e;

    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e        state_q,   state_d;
    logic [AW-1:0] cursor_q,  cursor_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          pend_r_q,  pend_r_d;
    logic          pend_l_q,  pend_l_d;
    logic          pend_c_q,  pend_c_d;
    logic          done_q,    done_d;

    // Button synchronisers: two metastability flops, then an edge register
    // that holds the previous synchronised level.
    logic          r_s1_q, r_s1_d;
    logic          r_s2_q, r_s2_d;
    logic          r_e_q,  r_e_d;
    logic          l_s1_q, l_s1_d;
    logic          l_s2_q, l_s2_d;
    logic          l_e_q,  l_e_d;

    logic          rise_r;
    logic          rise_l;
    logic          svc_r;
    logic          svc_l;
    logic          svc_c;

    // -----------------------------------------------------------------------
    // Synchroniser and edge detect
    // -----------------------------------------------------------------------
    always_comb begin
        r_s1_d = bntr;
        r_s2_d = r_s1_q;
        r_e_d  = r_s2_q;
        l_s1_d = bntl;
        l_s2_d = l_s1_q;
        l_e_d  = l_s2_q;
    end

    // The rise is visible two edges after the pin goes high, and it sets the
    // pending flag on the third edge.
    assign rise_r = r_s2_q & ~r_e_q;
    assign rise_l = l_s2_q & ~l_e_q;

    // -----------------------------------------------------------------------
    // Write port: only the CLEAR and PAINT states ever write.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_en   = (state_q != S_IDLE) && vblank;
        wr_addr = cursor_q;
        wr_data = color_sel;
        if (state_q == S_CLEAR) begin
            wr_addr = clr_cnt_q;
            wr_data = CLR_COLOR;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        clr_cnt_d = clr_cnt_q;
        done_d    = 1'b0;
        svc_r     = 1'b0;
        svc_l     = 1'b0;
        svc_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pend_c_q) begin
                    // A clear wins over cursor moves. The moves stay pending
                    // and are handled after the clear finishes.
                    svc_c     = 1'b1;
                    clr_cnt_d = '0;
                    state_d   = S_CLEAR;
                end else if (pend_r_q && pend_l_q) begin
                    // Opposite requests cancel each other: no move, no write.
                    svc_r = 1'b1;
                    svc_l = 1'b1;
                end else if (pend_r_q) begin
                    svc_r    = 1'b1;
                    cursor_d = cursor_q + ADDR_ONE;
                    state_d  = S_PAINT;
                end else if (pend_l_q) begin
                    svc_l    = 1'b1;
                    cursor_d = cursor_q - ADDR_ONE;
                    state_d  = S_PAINT;
                end
            end

            S_CLEAR: begin
                // The counter advances only when a write actually happens,
                // so a vblank gap pauses the sweep in place.
                if (wr_en) begin
                    clr_cnt_d = clr_cnt_q + ADDR_ONE;
                    if (clr_cnt_q == ADDR_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_PAINT: begin
                if (wr_en) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending flags hold one event each. A new event is dropped while the
    // flag is still set, including in the cycle where that flag is serviced.
    // -----------------------------------------------------------------------
    always_comb begin
        pend_r_d = pend_r_q ? ~svc_r : rise_r;
        pend_l_d = pend_l_q ? ~svc_l : rise_l;
        pend_c_d = pend_c_q ? ~svc_c : clear_req;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cursor_q  <= '0;
            clr_cnt_q <= '0;
            pend_r_q  <= 1'b0;
            pend_l_q  <= 1'b0;
            pend_c_q  <= 1'b0;
            done_q    <= 1'b0;
            r_s1_q    <= 1'b0;
            r_s2_q    <= 1'b0;
            r_e_q     <= 1'b0;
            l_s1_q    <= 1'b0;
            l_s2_q    <= 1'b0;
            l_e_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            clr_cnt_q <= clr_cnt_d;
            pend_r_q  <= pend_r_d;
            pend_l_q  <= pend_l_d;
            pend_c_q  <= pend_c_d;
            done_q    <= done_d;
            r_s1_q    <= r_s1_d;
            r_s2_q    <= r_s2_d;
            r_e_q     <= r_e_d;
            l_s1_q    <= l_s1_d;
            l_s2_q    <= l_s2_d;
            l_e_q     <= l_e_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cursor    = cursor_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
